// File: rtl/mem_pkg.sv
// Shared types and helpers for the block_memory backing store: FSM state
// encoding, the default access delay and the reset fill pattern.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  localparam int DEFAULT_MEM_DELAY = 30;

  // Reset content of byte k of block b: low 8 bits of its own byte address.
  function automatic logic [7:0] init_pattern(input int unsigned b,
                                              input int unsigned k,
                                              input int unsigned bytes_per_block = 4);
    int unsigned v;
    v = b * bytes_per_block + k;
    return v[7:0];
  endfunction

endpackage

// File: rtl/mem_delay_counter.sv
// Access-delay counter: loads 1 on accept, counts up while an access is in
// flight and flags the cycle on which MEM_DELAY has been reached.
module mem_delay_counter
  import mem_pkg::*;
#(
  parameter  int MEM_DELAY = DEFAULT_MEM_DELAY,
  localparam int CW        = $clog2(MEM_DELAY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(1);
    end else if (inc) begin
      count_reg <= count_reg + CW'(1);
    end else if (clear) begin
      count_reg <= '0;
    end
  end

  assign count    = count_reg;
  assign terminal = (count_reg == CW'(MEM_DELAY));

endmodule

// File: rtl/block_memory.sv
// Fixed-latency block backing store behind the L2 cache. Optional per-type
// completion counters are enabled with the BLOCK_MEMORY_STATS_EN macro.
module block_memory
  import mem_pkg::*;
#(
  parameter  int ADDR_LENGTH      = 10,
  parameter  int BLOCK_SIZE       = 32,
  parameter  int MEM_DELAY        = DEFAULT_MEM_DELAY,
  localparam int BYTE_SELECT_SIZE = $clog2(BLOCK_SIZE / 8),
  localparam int NUM_BLOCKS       = 2 ** (ADDR_LENGTH - BYTE_SELECT_SIZE),
  localparam int IDX_W            = ADDR_LENGTH - BYTE_SELECT_SIZE,
  localparam int BYTES            = BLOCK_SIZE / 8,
  localparam int CW               = $clog2(MEM_DELAY + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   we,
  input  logic [ADDR_LENGTH-1:0] addr,
  input  logic [BLOCK_SIZE-1:0]  data_in,
  output logic [BLOCK_SIZE-1:0]  data_out,
  output logic                   requestComplete,
  output logic                   busy
`ifdef BLOCK_MEMORY_STATS_EN
  ,
  output logic [15:0]            read_count,
  output logic [15:0]            write_count
`endif
);

  logic [BLOCK_SIZE-1:0] mem [NUM_BLOCKS];

  mem_state_t            state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  we_reg;
  logic [BLOCK_SIZE-1:0] wdata_reg;
  logic [BLOCK_SIZE-1:0] data_out_reg;
  logic                  complete_reg;
  logic                  busy_reg;

  logic                  cnt_load;
  logic                  cnt_inc;
  logic                  cnt_clear;
  logic [CW-1:0]         cnt_value;
  logic                  cnt_terminal;
  logic                  access_now;

  // Byte-select bits never reach the array; the whole block is returned.
  logic                  unused_byte_select;
  assign unused_byte_select = ^{addr[BYTE_SELECT_SIZE-1:0], cnt_value};

  assign cnt_load   = (state_reg == IDLE) && enable;
  assign access_now = (state_reg == BUSY) && cnt_terminal;
  assign cnt_inc    = (state_reg == BUSY) && !cnt_terminal;
  assign cnt_clear  = (state_reg != BUSY) && !cnt_load;

  mem_delay_counter #(
    .MEM_DELAY (MEM_DELAY)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .clear    (cnt_clear),
    .count    (cnt_value),
    .terminal (cnt_terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        for (int k = 0; k < BYTES; k++) begin
          mem[b][8*k +: 8] <= init_pattern(b, k, BYTES);
        end
      end
      state_reg    <= IDLE;
      idx_reg      <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      data_out_reg <= '0;
      complete_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      complete_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            idx_reg   <= addr[ADDR_LENGTH-1:BYTE_SELECT_SIZE];
            we_reg    <= we;
            wdata_reg <= data_in;
            busy_reg  <= 1'b1;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_terminal) begin
            if (we_reg) begin
              mem[idx_reg] <= wdata_reg;
              data_out_reg <= wdata_reg;
            end else begin
              data_out_reg <= mem[idx_reg];
            end
            complete_reg <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          // A still-high enable is the same miss; wait for it to drop.
          if (enable) begin
            state_reg <= HOLD;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        HOLD: begin
          if (!enable) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_out        = data_out_reg;
  assign requestComplete = complete_reg;
  assign busy            = busy_reg;

`ifdef BLOCK_MEMORY_STATS_EN
  logic [15:0] read_count_reg;
  logic [15:0] write_count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      read_count_reg  <= '0;
      write_count_reg <= '0;
    end else if (access_now) begin
      if (we_reg && (write_count_reg != 16'hFFFF)) begin
        write_count_reg <= write_count_reg + 16'd1;
      end
      if (!we_reg && (read_count_reg != 16'hFFFF)) begin
        read_count_reg <= read_count_reg + 16'd1;
      end
    end
  end

  assign read_count  = read_count_reg;
  assign write_count = write_count_reg;
`else
  logic unused_access_now;
  assign unused_access_now = access_now;
`endif

endmodule

// File: tb/tb_block_memory.sv
// Randomized scoreboard bench for block_memory: a driver issues requests and
// queues expected blocks from an array model; a monitor checks each strobe.
module tb_block_memory;

`ifdef BLOCK_MEMORY_STATS_EN
  localparam int D = 1;
`else
  localparam int D = 30;
`endif
  localparam int AL = 10;
  localparam int BS = 32;
  localparam int NB = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          we = 1'b0;
  logic [AL-1:0] addr = '0;
  logic [BS-1:0] data_in = '0;
  logic [BS-1:0] data_out;
  logic          requestComplete;
  logic          busy;
`ifdef BLOCK_MEMORY_STATS_EN
  logic [15:0]   read_count;
  logic [15:0]   write_count;
`endif

  block_memory #(
    .ADDR_LENGTH (AL),
    .BLOCK_SIZE  (BS),
    .MEM_DELAY   (D)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .we              (we),
    .addr            (addr),
    .data_in         (data_in),
    .data_out        (data_out),
    .requestComplete (requestComplete),
    .busy            (busy)
`ifdef BLOCK_MEMORY_STATS_EN
    ,
    .read_count      (read_count),
    .write_count     (write_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BS-1:0] model_mem [NB];
  logic [BS-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int accept_cyc = 0;
  bit busy_prev = 1'b0;

  task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < 4; k++) begin
        model_mem[b][8*k +: 8] = 8'((b * 4 + k) % 256);
      end
    end
    exp_rd = 0;
    exp_wr = 0;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (busy && !busy_prev) accept_cyc = cyc;
      busy_prev = busy;
      if (requestComplete) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got strobe with data %h, required none (cycle %0d)", data_out, cyc);
        end else begin
          logic [BS-1:0] e;
          e = exp_q.pop_front();
          check("data_out", data_out, e);
          check("latency", BS'(cyc - accept_cyc), BS'(D));
          $display("strobe cycle %0d data %h expected %h", cyc, data_out, e);
        end
      end
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy) begin
      @(negedge clk);
      t++;
      if (t > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, t);
        return;
      end
    end
  endtask

  task automatic scramble();
    addr    = AL'($urandom_range(0, 1023));
    we      = 1'($urandom_range(0, 1));
    data_in = $urandom;
  endtask

  // Issue one request; enable stays high for 'hold' cycles after accept
  // while the other inputs are scrambled to prove they are ignored.
  task automatic issue(input bit w, input logic [AL-1:0] a, input logic [BS-1:0] d, input int hold);
    logic [BS-1:0] e;
    int idx;
    wait_idle();
    enable  = 1'b1;
    we      = w;
    addr    = a;
    data_in = d;
    idx = int'(a) / 4;
    if (w) begin
      model_mem[idx] = d;
      e = d;
      exp_wr++;
    end else begin
      e = model_mem[idx];
      exp_rd++;
    end
    exp_q.push_back(e);
    $display("issue we=%0b addr=%0d data=%h hold=%0d expect=%h", w, a, d, hold, e);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(negedge clk);
    end
    if (hold >= D + 1) check("busy_in_hold", BS'(busy), BS'(1));
    enable = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, BS'(busy), '0);
    check({tag, "_strobe"}, BS'(requestComplete), '0);
    check({tag, "_data_out"}, data_out, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    issue(1'b0, 10'd4, '0, 0);
    check("pattern_const", model_mem[1], 32'h07060504);
    issue(1'b1, 10'd8, 32'hDEADBEEF, 1);
    issue(1'b0, 10'd11, '0, 0);
    issue(1'b0, 10'd12, '0, 2);

    // Level-held miss: only one completion, next request still accepted.
    issue(1'b0, 10'd20, '0, 80);
    issue(1'b1, 10'd44, 32'h12345678, 5);
    drain();

    // Reset while a read is in flight: no strobe, array back to the pattern.
    wait_idle();
    enable = 1'b1;
    we     = 1'b0;
    addr   = 10'd8;
    @(negedge clk);
    for (int i = 0; i < ((D < 10) ? D : 10) - 1; i++) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("midflight_reset");
    reset = 1'b1;
    repeat (D + 5) @(negedge clk);
    issue(1'b0, 10'd8, '0, 0);
    issue(1'b0, 10'd44, '0, 0);

    for (int n = 0; n < 30; n++) begin
      issue(1'($urandom_range(0, 1)), AL'($urandom_range(0, 1023)), $urandom,
            int'($urandom_range(0, D + 3)));
    end
    drain();

`ifdef BLOCK_MEMORY_STATS_EN
    check("read_count", BS'(read_count), BS'(exp_rd));
    check("write_count", BS'(write_count), BS'(exp_wr));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
